sipo_rx: RTL and testbench
==========================

SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the parallel word width (>=2).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port si, input, 1 bit, serial data, MSB of each word first.
REQ-005 SHALL have port shift_en, input, 1 bit; si is sampled only on edges where shift_en=1.
REQ-006 SHALL have port sync, input, 1 bit, frame restart that discards any partial word.
REQ-007 SHALL have port pready, input, 1 bit, consumer accepts pdata when pready=1 and pvalid=1.
REQ-008 SHALL have port clr_ovr, input, 1 bit, clears the sticky overrun flag.
REQ-009 SHALL have port pdata, output, WIDTH bits, registered completed word.
REQ-010 SHALL have port pvalid, output, 1 bit, pdata holds an unconsumed word.
REQ-011 SHALL have port overrun, output, 1 bit, sticky flag set when a completed word was dropped.
REQ-012 SHALL have port busy, output, 1 bit, high when a partial word is held (bit count != 0).

Function
REQ-013 SHALL hold a WIDTH-bit shift register; on shift_en it SHALL shift left, inserting si at bit 0, so the first bit received ends at pdata[WIDTH-1].
REQ-014 SHALL keep a bit counter 0..WIDTH-1, incremented on each shift_en and wrapped to 0 on the WIDTH-th bit.
REQ-015 On the edge sampling the WIDTH-th bit, SHALL form the word {sreg[WIDTH-2:0], si} with zero added latency: pdata/pvalid update at that same edge.
REQ-016 The output buffer SHALL be a two-state FSM: EMPTY (pvalid=0) and FULL (pvalid=1).
REQ-017 EMPTY->FULL SHALL occur on word completion; FULL->EMPTY SHALL occur on pready=1 with no completion on that edge.
REQ-018 In FULL, a completion on an edge with pready=1 SHALL load the new word and stay FULL, with no overrun.
REQ-019 In FULL, a completion on an edge with pready=0 SHALL drop the new word, keep pdata unchanged, and set overrun.
REQ-020 pdata SHALL change only on a load; it SHALL hold its value while pvalid=1 and pready=0.
REQ-021 sync=1 SHALL clear the bit counter; if shift_en=1 on the same edge, si SHALL be taken as bit 1 of a new word (counter becomes 1).
REQ-022 sync SHALL NOT affect pdata, pvalid or overrun.
REQ-023 overrun SHALL remain set until clr_ovr=1; if set and clear coincide on the same edge, set SHALL win.
REQ-024 busy SHALL be asserted whenever the bit counter is nonzero.

Reset
REQ-025 While rst_n=0, the block SHALL force: shift register 0, bit counter 0, FSM EMPTY, pdata 0, pvalid 0, overrun 0, busy 0.
REQ-026 Reset assertion mid-word SHALL discard the partial word; the first shift_en after release SHALL be bit 1 of a new word.

Structure
REQ-027 WIDTH default and the EMPTY/FULL state encoding SHALL reside in shared package piso_sipo_pkg, used by both serial transmit and receive blocks.
REQ-028 The bit counter with its wrap/sync logic SHALL be a sub-module sipo_bitcnt, outputting count and last_bit; everything else is in sipo_rx.

Verification (WIDTH=4)
REQ-029 Scenario: assert rst_n=0 for 2 cycles. Required: pdata=0, pvalid=0, overrun=0, busy=0.
REQ-030 Scenario: send bits 1,0,1,1 with shift_en and pready=1. Required: at the 4th edge, pdata=4'b1011, pvalid=1 for one cycle, busy=0.
REQ-031 Scenario: with pready=0, send words 1011 then 0110. Required: pdata stays 1011 and overrun=1; after clr_ovr pulse, overrun=0.
REQ-032 Scenario: pready=1 on the edge the second word 0110 completes. Required: pdata=0110, pvalid=1, overrun=0.
REQ-033 Scenario: send 1,1; then sync with shift_en and si=0; then send 1,0,1. Required: pdata=4'b0101, with busy=1 between sync and completion.
REQ-034 Scenario: pulse rst_n low after 2 bits; then send 0,0,1,1. Required: pdata=4'b0011, with no trace of the earlier bits.

Source files
------------

// File: rtl/piso_sipo_pkg.sv
// Shared definitions for the serial transmit and receive blocks:
// default word width, output-buffer state encoding and a counter-width helper.
package piso_sipo_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Bits needed to count 0..w-1, never less than one.
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sipo_bitcnt.sv
// Bit position counter for the serial receiver. Counts sampled bits 0..WIDTH-1,
// wraps on the last bit of a word and restarts on sync.
module sipo_bitcnt
  import piso_sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             sync,
  output logic [CNT_W-1:0] count,
  output logic             last_bit
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Last bit of a word: a shift at the top position. A sync on the same edge
  // makes this bit the first of a new word instead (WIDTH >= 2).
  always_comb begin
    last_bit = shift_en && !sync && (count_q == CNT_W'(WIDTH - 1));
  end

  // Next count: sync restarts the word, otherwise advance and wrap per shift.
  always_comb begin
    count_d = count_q;
    if (sync) begin
      count_d = shift_en ? CNT_W'(1) : '0;
    end else if (shift_en) begin
      count_d = last_bit ? '0 : count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver. Assembles MSB-first words, presents each
// completed word through a single-entry valid/ready buffer and flags words
// dropped while the buffer is occupied and not being drained.
module sipo_rx
  import piso_sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             si,
  input  logic             shift_en,
  input  logic             sync,
  input  logic             pready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] pdata,
  output logic             pvalid,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] count;
  logic             last_bit;
  buf_state_e       state_q;
  logic [WIDTH-1:0] pdata_q;
  logic             ovr_q;

  sipo_bitcnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bitcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .sync     (sync),
    .count    (count),
    .last_bit (last_bit)
  );

  // Shift left on every sampled bit; the completed word includes the bit
  // arriving on this edge so it can be loaded with no extra latency.
  always_comb begin
    sreg_d = shift_en ? {sreg_q[WIDTH-2:0], si} : sreg_q;
    word   = {sreg_q[WIDTH-2:0], si};
  end

  // Shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  // Output buffer FSM with registered word and sticky overrun (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      pdata_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (clr_ovr) begin
        ovr_q <= 1'b0;
      end
      case (state_q)
        BUF_EMPTY: begin
          if (last_bit) begin
            pdata_q <= word;
            state_q <= BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (last_bit) begin
            if (pready) begin
              pdata_q <= word;
            end else begin
              ovr_q <= 1'b1;
            end
          end else if (pready) begin
            state_q <= BUF_EMPTY;
          end
        end
        default: state_q <= BUF_EMPTY;
      endcase
    end
  end

  assign pdata   = pdata_q;
  assign pvalid  = (state_q == BUF_FULL);
  assign overrun = ovr_q;
  assign busy    = (count != '0);

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx at WIDTH=4: directed scenarios plus a randomised stream,
// with a behavioural reference and a queue of words expected at the consumer.
module tb_sipo_rx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         si = 1'b0;
  logic         shift_en = 1'b0;
  logic         sync = 1'b0;
  logic         pready = 1'b0;
  logic         clr_ovr = 1'b0;
  logic [W-1:0] pdata;
  logic         pvalid;
  logic         overrun;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // reference state
  int           mcnt;
  logic [W-1:0] msh;
  logic         mfull;
  logic [W-1:0] mword;
  logic         movr;
  logic [W-1:0] sb_q[$];

  sipo_rx #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .si       (si),
    .shift_en (shift_en),
    .sync     (sync),
    .pready   (pready),
    .clr_ovr  (clr_ovr),
    .pdata    (pdata),
    .pvalid   (pvalid),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mcnt  = 0;
    msh   = '0;
    mfull = 1'b0;
    mword = '0;
    movr  = 1'b0;
    sb_q.delete();
  endtask

  // One clock: drive inputs, consume at the edge if handshaking, then update
  // the reference and compare every output just after the edge.
  task automatic step(input logic s, input logic en, input logic sy,
                      input logic rdy, input logic clr);
    logic         done;
    logic         set;
    logic [W-1:0] w;
    logic [W-1:0] exp_w;
    si = s; shift_en = en; sync = sy; pready = rdy; clr_ovr = clr;
    @(negedge clk);
    if (pvalid && pready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_word", 32'(pdata), 32'hFFFF_FFFF);
      end else begin
        exp_w = sb_q.pop_front();
        chk("sb_word", 32'(pdata), 32'(exp_w));
      end
    end
    @(posedge clk);
    #1;
    done = 1'b0;
    set  = 1'b0;
    w    = '0;
    if (sy) mcnt = 0;
    if (en) begin
      msh  = {msh[W-2:0], s};
      mcnt = mcnt + 1;
      if (mcnt == W) begin
        done = 1'b1;
        w    = msh;
        mcnt = 0;
      end
    end
    if (done) begin
      if (!mfull || rdy) begin
        mword = w;
        mfull = 1'b1;
        sb_q.push_back(w);
      end else begin
        set = 1'b1;
      end
    end else if (mfull && rdy) begin
      mfull = 1'b0;
    end
    movr = set ? 1'b1 : (clr ? 1'b0 : movr);
    chk("pvalid", 32'(pvalid), 32'(mfull));
    chk("pdata", 32'(pdata), 32'(mword));
    chk("overrun", 32'(overrun), 32'(movr));
    chk("busy", 32'(busy), 32'(mcnt != 0));
  endtask

  task automatic send_word(input logic [W-1:0] wd, input logic rdy_last, input logic rdy_rest);
    for (int b = W - 1; b >= 0; b--) begin
      step(wd[b], 1'b1, 1'b0, (b == 0) ? rdy_last : rdy_rest, 1'b0);
    end
  endtask

  initial begin
    // reset held for two cycles
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pdata", 32'(pdata), 32'h0);
    chk("rst_pvalid", 32'(pvalid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    // single word with consumer ready
    send_word(4'b1011, 1'b1, 1'b1);
    chk("w1_pdata", 32'(pdata), 32'hB);
    chk("w1_pvalid", 32'(pvalid), 32'h1);
    chk("w1_busy", 32'(busy), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("w1_pvalid_one_cycle", 32'(pvalid), 32'h0);

    // consumer stalled: second word is dropped
    send_word(4'b1011, 1'b0, 1'b0);
    send_word(4'b0110, 1'b0, 1'b0);
    chk("ovr_pdata_hold", 32'(pdata), 32'hB);
    chk("ovr_set", 32'(overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_cleared", 32'(overrun), 32'h0);

    // consumer ready exactly on the completing edge
    send_word(4'b0110, 1'b1, 1'b0);
    chk("rdy_on_done_pdata", 32'(pdata), 32'h6);
    chk("rdy_on_done_pvalid", 32'(pvalid), 32'h1);
    chk("rdy_on_done_ovr", 32'(overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // sync restart mid-word, shift on the same edge
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sync_busy", 32'(busy), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sync_busy_mid", 32'(busy), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sync_pdata", 32'(pdata), 32'h5);
    chk("sync_pvalid", 32'(pvalid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // asynchronous reset pulse mid-word
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_pdata", 32'(pdata), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_word(4'b0011, 1'b0, 1'b0);
    chk("arst_word", 32'(pdata), 32'h3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // randomised stream with gaps, stalls, occasional sync and clear
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] rw;
      rw = W'($urandom);
      for (int b = W - 1; b >= 0; b--) begin
        while ($urandom_range(0, 3) == 0) begin
          step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end
        step(rw[b], 1'b1, 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 7) == 0));
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench did not finish");
  end

endmodule
